branch_predict_unit: RTL
========================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter PW, default 9, PC width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16, predictor table depth; a power of two, at least 2; IDX = log2(ENTRIES).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port f_pc, input, PW, fetch-stage PC to predict.
REQ-006 SHALL have port pred_taken, output, 1, fetch prediction: taken.
REQ-007 SHALL have port pred_target, output, 32, fetch predicted target.
REQ-008 SHALL have port ex_valid, input, 1, execute-stage instruction valid (not stalled or bubbled).
REQ-009 SHALL have port ex_is_ctrl, input, 1, execute instruction is branch, jal or jalr.
REQ-010 SHALL have ports ex_pc (PW), imm_value (32) and alu_result (32), all inputs: execute PC, immediate, and jalr target.
REQ-011 SHALL have ports jalr_sel and branch_sel, inputs, 1 each: jalr taken; branch or jal taken.
REQ-012 SHALL have ports ex_pred_taken (1) and ex_pred_target (32), inputs: the prediction piped with the instruction.
REQ-013 SHALL have ports pc_4, pc_imm, redirect_pc, outputs, 32 each; and redirect, output, 1, mispredict flush request.

Function
REQ-014 SHALL zero-extend ex_pc to 32 bits; pc_4 = pc32+4 and pc_imm = pc32+imm_value, both modulo 2^32.
REQ-015 SHALL derive actual_taken = jalr_sel|branch_sel, and actual_target = alu_result if jalr_sel, else pc_imm.
REQ-016 SHALL index the table with pc[IDX+1:2] and tag with pc[PW-1:IDX+2]; each entry holds valid, tag, 32-bit target and 2-bit counter.
REQ-017 SHALL assert pred_taken combinationally when the f_pc entry is valid, its tag matches and counter[1]=1.
REQ-018 SHALL drive pred_target = entry target when pred_taken=1, else 0.
REQ-019 SHALL assert redirect combinationally only when ex_valid & ex_is_ctrl, and either actual_taken != ex_pred_taken, or both are taken and actual_target != ex_pred_target.
REQ-020 SHALL drive redirect_pc = actual_target if actual_taken, else pc_4, and 0 when redirect=0.
REQ-021 SHALL update the table at the next edge only when ex_valid & ex_is_ctrl.
REQ-022 On an update hit, SHALL increment the counter saturating at 11 when taken, and decrement it saturating at 00 when not taken.
REQ-023 On an update hit that is taken, SHALL write actual_target into the entry.
REQ-024 On an update miss that is taken, SHALL allocate the entry, overwriting the prior occupant: valid=1, new tag, target, counter=10.
REQ-025 On an update miss that is not taken, SHALL leave the table unchanged.
REQ-026 When f_pc and ex_pc hit the same index in one cycle, the lookup SHALL return the pre-update contents; no bypass.
REQ-027 Prediction-to-update latency SHALL be one clock: an update is visible to lookups in the cycle after the edge.

Reset
REQ-028 While reset=1 at an edge, SHALL clear all valid bits, set all counters to 01 and all targets to 0; reset SHALL override any simultaneous update.
REQ-029 During and after reset, pred_taken SHALL be 0 until an allocation occurs; the combinational outputs follow their inputs.

Configuration
REQ-030 With BP_PERF_EN defined, SHALL add outputs perf_ctrl (32) and perf_mispred (32), which count updates and redirects respectively, wrap at 2^32 and reset to 0.
REQ-031 Without BP_PERF_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package bp_pkg SHALL hold the entry struct typedef and the counter constants SNT=00, WNT=01, WT=10, ST=11.
REQ-033 Table storage and the saturating update logic SHALL live in sub-module bp_entry_table; redirect and target arithmetic stay in the top.

Verification (PW=9, ENTRIES=16)
REQ-034 Reset, then f_pc=0x040 -> pred_taken=0 and pred_target=0.
REQ-035 Ex: pc=0x040, imm=0x20, branch_sel=1, pred 0 -> redirect=1 and redirect_pc=0x60; next cycle f_pc=0x040 gives pred_taken=1 and pred_target=0x60.
REQ-036 The same branch taken 3 more times, then not taken twice -> counter goes 10→11→11→11→10→01, and pred_taken=0 after the final update.
REQ-037 Jalr at 0x080 with alu_result=0x1F0 and ex_pred_target=0x100, pred 1 -> redirect=1 and redirect_pc=0x1F0.
REQ-038 Not taken at 0x044 with pred 1 -> redirect_pc=0x048; a taken branch at 0x140 (same index as 0x040, different tag) replaces entry 0x040.
REQ-039 reset=1 in the same cycle as a taken update -> table stays cleared; with BP_PERF_EN, perf_ctrl=0.

Source files
------------

// File: rtl/bp_pkg.sv
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and 2-bit counter encodings for the branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Tag field is sized for the widest legal PC; narrower tags are zero-extended.
  localparam int TAG_MAX = 32;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [31:0]        target;
    logic [1:0]         ctr;
  } bp_entry_t;

endpackage

`default_nettype wire

// File: rtl/bp_entry_table.sv
// ============================================================================
// Module      : bp_entry_table
// Description : Direct-mapped predictor table with 2-bit saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_entry_table
  import bp_pkg::*;
#(
  parameter int PW      = 9,
  parameter int ENTRIES = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] i_lookup_pc,
  output logic          o_hit_taken,
  output logic [31:0]   o_hit_target,
  input  logic          i_upd_en,
  input  logic [PW-1:0] i_upd_pc,
  input  logic          i_upd_taken,
  input  logic [31:0]   i_upd_target
);

  localparam int IDX = $clog2(ENTRIES);

  bp_entry_t          r_tbl [ENTRIES];
  bp_entry_t          w_lk_ent;
  bp_entry_t          w_up_ent;
  logic [IDX-1:0]     w_lk_idx;
  logic [IDX-1:0]     w_up_idx;
  logic [TAG_MAX-1:0] w_lk_tag;
  logic [TAG_MAX-1:0] w_up_tag;
  logic               w_up_hit;
  logic               w_unused;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == ST)  ? ST  : c + 2'd1;
    else       return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  assign w_lk_idx = i_lookup_pc[IDX+1:2];
  assign w_up_idx = i_upd_pc[IDX+1:2];
  assign w_lk_tag = TAG_MAX'(i_lookup_pc[PW-1:IDX+2]);
  assign w_up_tag = TAG_MAX'(i_upd_pc[PW-1:IDX+2]);
  assign w_unused = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

  // Lookup reads the registered contents only, so a same-cycle update is not bypassed.
  assign w_lk_ent     = r_tbl[w_lk_idx];
  assign w_up_ent     = r_tbl[w_up_idx];
  assign w_up_hit     = w_up_ent.valid && (w_up_ent.tag == w_up_tag);
  assign o_hit_taken  = w_lk_ent.valid && (w_lk_ent.tag == w_lk_tag) && w_lk_ent.ctr[1];
  assign o_hit_target = o_hit_taken ? w_lk_ent.target : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_tbl[i] <= '{valid: 1'b0, tag: '0, target: 32'd0, ctr: WNT};
      end
    end else if (i_upd_en) begin
      if (w_up_hit) begin
        r_tbl[w_up_idx].ctr <= ctr_next(w_up_ent.ctr, i_upd_taken);
        if (i_upd_taken) r_tbl[w_up_idx].target <= i_upd_target;
      end else if (i_upd_taken) begin
        r_tbl[w_up_idx] <= '{valid: 1'b1, tag: w_up_tag, target: i_upd_target, ctr: WT};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predict_unit.sv
// ============================================================================
// Module      : branch_predict_unit
// Description : Fetch-stage predictor plus execute-stage redirect resolution.
//               Define BP_PERF_EN to add perf_ctrl / perf_mispred counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int PW      = 9,
  parameter int ENTRIES = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] f_pc,
  output logic          pred_taken,
  output logic [31:0]   pred_target,
  input  logic          ex_valid,
  input  logic          ex_is_ctrl,
  input  logic [PW-1:0] ex_pc,
  input  logic [31:0]   imm_value,
  input  logic [31:0]   alu_result,
  input  logic          jalr_sel,
  input  logic          branch_sel,
  input  logic          ex_pred_taken,
  input  logic [31:0]   ex_pred_target,
  output logic [31:0]   pc_4,
  output logic [31:0]   pc_imm,
  output logic [31:0]   redirect_pc,
`ifdef BP_PERF_EN
  output logic [31:0]   perf_ctrl,
  output logic [31:0]   perf_mispred,
`endif
  output logic          redirect
);

  logic [31:0] w_pc32;
  logic        w_actual_taken;
  logic [31:0] w_actual_target;
  logic        w_upd_en;

  assign w_pc32          = 32'(ex_pc);
  assign pc_4            = w_pc32 + 32'd4;
  assign pc_imm          = w_pc32 + imm_value;
  assign w_actual_taken  = jalr_sel | branch_sel;
  assign w_actual_target = jalr_sel ? alu_result : pc_imm;
  assign w_upd_en        = ex_valid & ex_is_ctrl;

  // Target mismatch only matters when both prediction and outcome are taken.
  assign redirect = w_upd_en &&
                    ((w_actual_taken != ex_pred_taken) ||
                     (w_actual_taken && ex_pred_taken && (w_actual_target != ex_pred_target)));

  assign redirect_pc = !redirect       ? 32'd0 :
                       w_actual_taken  ? w_actual_target : pc_4;

  bp_entry_table #(
    .PW      (PW),
    .ENTRIES (ENTRIES)
  ) u_table (
    .clk          (clk),
    .reset        (reset),
    .i_lookup_pc  (f_pc),
    .o_hit_taken  (pred_taken),
    .o_hit_target (pred_target),
    .i_upd_en     (w_upd_en),
    .i_upd_pc     (ex_pc),
    .i_upd_taken  (w_actual_taken),
    .i_upd_target (w_actual_target)
  );

`ifdef BP_PERF_EN
  logic [31:0] r_perf_ctrl;
  logic [31:0] r_perf_mispred;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_ctrl    <= 32'd0;
      r_perf_mispred <= 32'd0;
    end else begin
      if (w_upd_en) r_perf_ctrl    <= r_perf_ctrl + 32'd1;
      if (redirect) r_perf_mispred <= r_perf_mispred + 32'd1;
    end
  end

  assign perf_ctrl    = r_perf_ctrl;
  assign perf_mispred = r_perf_mispred;
`endif

endmodule

`default_nettype wire
